// File: rtl/bp_be_replay_fifo.sv
// Replay buffer: entries stay resident from enqueue until explicitly committed, so the
// consumer can be rewound to the oldest uncommitted entry after a poison or flush.
module bp_be_replay_fifo #(
    parameter int unsigned width_p        = 64,
    parameter int unsigned els_p          = 8,
    parameter int unsigned max_inflight_p = els_p,
    localparam int unsigned ptr_width_lp  = $clog2(els_p) + 1,
    localparam int unsigned cnt_width_lp  = $clog2(els_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [width_p-1:0]      data_i,
    input  logic                    v_i,
    output logic                    ready_o,
    output logic [width_p-1:0]      data_o,
    output logic                    v_o,
    input  logic                    yumi_i,
    input  logic                    commit_v_i,
    input  logic                    roll_v_i,
    input  logic                    clr_v_i,
    output logic [cnt_width_lp-1:0] count_o,
    output logic [cnt_width_lp-1:0] inflight_o,
    output logic                    empty_o,
    output logic                    full_o
);

    localparam int unsigned idx_width_lp = ptr_width_lp - 1;

    logic [width_p-1:0]      mem_r [els_p];
    logic [ptr_width_lp-1:0] cptr_r, rptr_r, wptr_r;
    logic [ptr_width_lp-1:0] cptr_n, rptr_n, wptr_n;
    logic [ptr_width_lp-1:0] count_full, inflight_full;
    logic                    out_of_reset_r;
    logic                    enq, issue, commit;

    assign count_full    = wptr_r - cptr_r;
    assign inflight_full = rptr_r - cptr_r;
    assign count_o       = cnt_width_lp'(count_full);
    assign inflight_o    = cnt_width_lp'(inflight_full);

    // Full when low bits match and the wrap bits differ.
    assign full_o  = (wptr_r[idx_width_lp-1:0] == cptr_r[idx_width_lp-1:0])
                   & (wptr_r[idx_width_lp] != cptr_r[idx_width_lp]);
    assign empty_o = (wptr_r == cptr_r);

    assign ready_o = ~full_o & out_of_reset_r;
    assign v_o     = (rptr_r != wptr_r)
                   & (inflight_o < cnt_width_lp'(max_inflight_p))
                   & out_of_reset_r;
    assign data_o  = mem_r[rptr_r[idx_width_lp-1:0]];

    assign enq    = v_i & ready_o;
    assign issue  = yumi_i & v_o;
    assign commit = commit_v_i & (inflight_full != '0);

    // Rollback overrides issue; clear truncates the write pointer to wherever reads end up.
    always_comb begin
        cptr_n = cptr_r + ptr_width_lp'(commit);
        rptr_n = rptr_r + ptr_width_lp'(issue);
        wptr_n = wptr_r + ptr_width_lp'(enq);
        if (roll_v_i) begin
            rptr_n = cptr_n;
        end
        if (clr_v_i) begin
            wptr_n = rptr_n;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cptr_r         <= '0;
            rptr_r         <= '0;
            wptr_r         <= '0;
            out_of_reset_r <= 1'b0;
        end else begin
            cptr_r         <= cptr_n;
            rptr_r         <= rptr_n;
            wptr_r         <= wptr_n;
            out_of_reset_r <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq && !clr_v_i) begin
            mem_r[wptr_r[idx_width_lp-1:0]] <= data_i;
        end
    end

`ifndef SYNTHESIS
    yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
    commit_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                   commit_v_i |-> (inflight_o != '0));
`endif

endmodule

// File: tb/tb_bp_be_replay_fifo.sv
// Scoreboard bench for bp_be_replay_fifo: a queue model of held entries plus in-flight count.
module tb_bp_be_replay_fifo;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int MI = 2;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic [W-1:0] data_i;
    logic         v_i, ready_o;
    logic [W-1:0] data_o;
    logic         v_o, yumi_i, commit_v_i, roll_v_i, clr_v_i;
    logic [3:0]   count_o, inflight_o;
    logic         empty_o, full_o;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: ent holds every uncommitted entry oldest first; infl of them are issued.
    logic [W-1:0] ent[$];
    logic [W-1:0] exp_q[$];
    int           infl;
    bit           oor;

    bp_be_replay_fifo #(.width_p(W), .els_p(N), .max_inflight_p(MI)) dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .data_i     (data_i),
        .v_i        (v_i),
        .ready_o    (ready_o),
        .data_o     (data_o),
        .v_o        (v_o),
        .yumi_i     (yumi_i),
        .commit_v_i (commit_v_i),
        .roll_v_i   (roll_v_i),
        .clr_v_i    (clr_v_i),
        .count_o    (count_o),
        .inflight_o (inflight_o),
        .empty_o    (empty_o),
        .full_o     (full_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic idle();
        v_i = 0; data_i = '0; yumi_i = 0; commit_v_i = 0; roll_v_i = 0; clr_v_i = 0;
    endtask

    // Advance one clock, updating the model with the inputs presented before the edge.
    task automatic step();
        int cnt;
        bit rdy, vo, enq, iss, com;
        cnt = ent.size();
        rdy = (cnt < N) && oor;
        vo  = (infl < cnt) && (infl < MI) && oor;
        enq = v_i && rdy;
        iss = yumi_i && vo;
        com = commit_v_i && (infl > 0);
        @(posedge clk_i);
        if (com) begin
            void'(ent.pop_front());
            infl--;
        end
        if (roll_v_i) infl = 0;
        else if (iss) infl++;
        if (clr_v_i) begin
            while (ent.size() > infl) void'(ent.pop_back());
        end else if (enq) begin
            ent.push_back(data_i);
        end
        oor = 1;
        #1;
    endtask

    task automatic enqueue(input logic [W-1:0] d);
        v_i = 1; data_i = d; step(); v_i = 0;
    endtask

    task automatic drop_all();
        clr_v_i = 1; roll_v_i = 1; step(); clr_v_i = 0; roll_v_i = 0;
    endtask

    task automatic test_reset();
        #3;
        n_chk++; if (ready_o !== 1'b0) $display("FAIL rst_ready: got %b want 0", ready_o); else n_pass++;
        n_chk++; if (v_o !== 1'b0) $display("FAIL rst_v: got %b want 0", v_o); else n_pass++;
        n_chk++; if (count_o !== 4'd0) $display("FAIL rst_count: got %0d want 0", count_o); else n_pass++;
        n_chk++; if (inflight_o !== 4'd0) $display("FAIL rst_infl: got %0d want 0", inflight_o); else n_pass++;
        n_chk++; if (empty_o !== 1'b1) $display("FAIL rst_empty: got %b want 1", empty_o); else n_pass++;
        n_chk++; if (full_o !== 1'b0) $display("FAIL rst_full: got %b want 0", full_o); else n_pass++;
        @(posedge clk_i); #1;
        reset_n_i = 1;
        #1;
        n_chk++; if (ready_o !== 1'b0) $display("FAIL rel_ready_early: got %b want 0", ready_o); else n_pass++;
        step();
        n_chk++; if (ready_o !== 1'b1) $display("FAIL rel_ready: got %b want 1", ready_o); else n_pass++;
    endtask

    task automatic test_fill_drain();
        logic [W-1:0] exp;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                exp_q.push_back(W'((r == 0 ? 'h10 : 'h20) + i));
                enqueue(W'((r == 0 ? 'h10 : 'h20) + i));
            end
            n_chk++; if (full_o !== 1'b1) $display("FAIL fill_full: got %b want 1", full_o); else n_pass++;
            n_chk++; if (ready_o !== 1'b0) $display("FAIL fill_ready: got %b want 0", ready_o); else n_pass++;
            n_chk++; if (count_o !== 4'd8) $display("FAIL fill_count: got %0d want 8", count_o); else n_pass++;
            for (int i = 0; i < N; i++) begin
                n_chk++; if (v_o !== 1'b1) $display("FAIL drain_v: got %b want 1", v_o); else n_pass++;
                exp = exp_q.pop_front();
                n_chk++; if (data_o !== exp) $display("FAIL drain_data: got %h want %h", data_o, exp); else n_pass++;
                yumi_i = 1; step(); yumi_i = 0;
                commit_v_i = 1; step(); commit_v_i = 0;
            end
            n_chk++; if (empty_o !== 1'b1) $display("FAIL drain_empty: got %b want 1", empty_o); else n_pass++;
            n_chk++; if (count_o !== 4'd0) $display("FAIL drain_count: got %0d want 0", count_o); else n_pass++;
        end
    endtask

    task automatic test_inflight_cap();
        int issued = 0;
        for (int i = 0; i < 4; i++) enqueue(W'('h30 + i));
        for (int k = 0; k < 4; k++) begin
            yumi_i = v_o;
            if (v_o) issued++;
            step();
        end
        yumi_i = 0;
        n_chk++; if (issued != MI) $display("FAIL cap_issues: got %0d want %0d", issued, MI); else n_pass++;
        n_chk++; if (v_o !== 1'b0) $display("FAIL cap_v: got %b want 0", v_o); else n_pass++;
        n_chk++; if (inflight_o !== 4'd2) $display("FAIL cap_infl: got %0d want 2", inflight_o); else n_pass++;
        commit_v_i = 1; step(); commit_v_i = 0;
        n_chk++; if (v_o !== 1'b1) $display("FAIL cap_reopen: got %b want 1", v_o); else n_pass++;
        n_chk++; if (data_o !== 16'h0032) $display("FAIL cap_data: got %h want 0032", data_o); else n_pass++;
        drop_all();
        n_chk++; if (empty_o !== 1'b1) $display("FAIL cap_drop: got %b want 1", empty_o); else n_pass++;
    endtask

    task automatic test_rollback();
        enqueue(16'h00A1); enqueue(16'h00B2); enqueue(16'h00C3);
        yumi_i = 1; step(); step(); yumi_i = 0;
        commit_v_i = 1; step(); commit_v_i = 0;
        n_chk++; if (data_o !== 16'h00C3) $display("FAIL roll_pre: got %h want 00c3", data_o); else n_pass++;
        roll_v_i = 1; yumi_i = 1; step(); roll_v_i = 0; yumi_i = 0;
        n_chk++; if (data_o !== 16'h00B2) $display("FAIL roll_data: got %h want 00b2", data_o); else n_pass++;
        n_chk++; if (inflight_o !== 4'd0) $display("FAIL roll_infl: got %0d want 0", inflight_o); else n_pass++;
        n_chk++; if (count_o !== 4'd2) $display("FAIL roll_count: got %0d want 2", count_o); else n_pass++;
        yumi_i = 1; step();
        n_chk++; if (data_o !== 16'h00C3) $display("FAIL reissue: got %h want 00c3", data_o); else n_pass++;
        step(); yumi_i = 0;
        n_chk++; if (inflight_o !== 4'd2) $display("FAIL reissue_infl: got %0d want 2", inflight_o); else n_pass++;
        drop_all();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 4; i++) enqueue(W'('hD1 + i));
        yumi_i = 1; step(); yumi_i = 0;
        clr_v_i = 1; v_i = 1; data_i = 16'h00E5;
        n_chk++; if (ready_o !== 1'b1) $display("FAIL clr_ready: got %b want 1", ready_o); else n_pass++;
        step(); clr_v_i = 0; v_i = 0;
        n_chk++; if (count_o !== 4'd1) $display("FAIL clr_count: got %0d want 1", count_o); else n_pass++;
        n_chk++; if (inflight_o !== 4'd1) $display("FAIL clr_infl: got %0d want 1", inflight_o); else n_pass++;
        n_chk++; if (v_o !== 1'b0) $display("FAIL clr_v: got %b want 0", v_o); else n_pass++;
        drop_all();
        n_chk++; if (count_o !== 4'd0) $display("FAIL clrroll_count: got %0d want 0", count_o); else n_pass++;
        n_chk++; if (empty_o !== 1'b1) $display("FAIL clrroll_empty: got %b want 1", empty_o); else n_pass++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) enqueue(W'('h50 + i));
        yumi_i = 1; step(); step(); yumi_i = 0;
        n_chk++; if (count_o !== 4'd5) $display("FAIL ar_count_pre: got %0d want 5", count_o); else n_pass++;
        #3;
        reset_n_i = 0;
        #1;
        ent.delete(); infl = 0; oor = 0;
        n_chk++; if (ready_o !== 1'b0) $display("FAIL ar_ready: got %b want 0", ready_o); else n_pass++;
        n_chk++; if (v_o !== 1'b0) $display("FAIL ar_v: got %b want 0", v_o); else n_pass++;
        n_chk++; if (count_o !== 4'd0) $display("FAIL ar_count: got %0d want 0", count_o); else n_pass++;
        n_chk++; if (inflight_o !== 4'd0) $display("FAIL ar_infl: got %0d want 0", inflight_o); else n_pass++;
        n_chk++; if (empty_o !== 1'b1) $display("FAIL ar_empty: got %b want 1", empty_o); else n_pass++;
        @(posedge clk_i); #1;
        reset_n_i = 1;
        #1;
        n_chk++; if (ready_o !== 1'b0) $display("FAIL ar_rel_early: got %b want 0", ready_o); else n_pass++;
        step();
        n_chk++; if (ready_o !== 1'b1) $display("FAIL ar_rel_ready: got %b want 1", ready_o); else n_pass++;
    endtask

    task automatic test_random();
        int cnt;
        bit vo, rdy;
        for (int c = 0; c < 10000; c++) begin
            cnt = ent.size();
            rdy = (cnt < N) && oor;
            vo  = (infl < cnt) && (infl < MI) && oor;
            n_chk++; if (count_o !== 4'(cnt)) $display("FAIL rnd_count: got %0d want %0d", count_o, cnt); else n_pass++;
            n_chk++; if (inflight_o !== 4'(infl)) $display("FAIL rnd_infl: got %0d want %0d", inflight_o, infl); else n_pass++;
            n_chk++; if (v_o !== vo) $display("FAIL rnd_v: got %b want %b", v_o, vo); else n_pass++;
            n_chk++; if (ready_o !== rdy) $display("FAIL rnd_ready: got %b want %b", ready_o, rdy); else n_pass++;
            n_chk++; if (full_o !== (cnt == N)) $display("FAIL rnd_full: got %b want %b", full_o, cnt == N); else n_pass++;
            n_chk++; if (empty_o !== (cnt == 0)) $display("FAIL rnd_empty: got %b want %b", empty_o, cnt == 0); else n_pass++;
            if (vo) begin
                n_chk++;
                if (data_o !== ent[infl]) $display("FAIL rnd_data: got %h want %h", data_o, ent[infl]);
                else n_pass++;
            end
            v_i        = 1'($urandom_range(0, 1));
            data_i     = W'($urandom);
            yumi_i     = vo && ($urandom_range(0, 2) != 0);
            commit_v_i = (infl > 0) && ($urandom_range(0, 1) != 0);
            roll_v_i   = ($urandom_range(0, 15) == 0);
            clr_v_i    = ($urandom_range(0, 19) == 0);
            step();
        end
        idle();
    endtask

    initial begin
        reset_n_i = 0;
        idle();
        infl = 0;
        oor  = 0;
        test_reset();
        test_fill_drain();
        test_inflight_cap();
        test_rollback();
        test_clear();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bp_be_replay_fifo.md
# bp_be_replay_fifo

Parametrised replay buffer between a request source and a pipelined consumer such as the D$ request port. It holds every entry from enqueue until it is explicitly committed, so the consumer can be rewound to the oldest uncommitted entry after a poison or flush. It generalises the fixed 8-entry rollback FIFO with:
- configurable depth and width
- an in-flight issue limit
- explicit per-entry commit
- a combined clear/rollback mode
- occupancy outputs for credit logic

## Interface
Parameters:
- width_p, 64, payload width in bits
- els_p, 8, entry count; power of two, ≥2
- max_inflight_p, els_p, max issued-but-uncommitted entries; 1..els_p
- ptr_width_lp (localparam), $clog2(els_p)+1, pointer width including wrap bit
- cnt_width_lp (localparam), $clog2(els_p+1), counter width

Ports:
- clk_i  in  1  clock, all state on posedge
- reset_n_i  in  1  asynchronous, active-low reset
- data_i  in  width_p  enqueue payload
- v_i  in  1  enqueue valid
- ready_o  out  1  enqueue ready; ready→valid handshake, v_i may depend on ready_o
- data_o  out  width_p  payload at read pointer
- v_o  out  1  issue valid
- yumi_i  in  1  consumer accepts data_o; legal only when v_o=1
- commit_v_i  in  1  retire oldest in-flight entry
- roll_v_i  in  1  rewind read pointer to commit pointer
- clr_v_i  in  1  discard all unissued entries
- count_o  out  cnt_width_lp  entries held (wptr−cptr)
- inflight_o  out  cnt_width_lp  issued, uncommitted entries (rptr−cptr)
- empty_o  out  1  count_o==0
- full_o  out  1  count_o==els_p

## Operation
- Storage: flop array of els_p×width_p. Three pointers of ptr_width_lp bits:
  - cptr: commit pointer
  - rptr: read pointer
  - wptr: write pointer
- Invariant: cptr ≤ rptr ≤ wptr (modular). Low bits index the array; the MSB is the wrap bit.
- Full: wptr and cptr have equal low bits and differing MSB. Pointer wrap from els_p−1 to 0 toggles the MSB.
- ready_o = ~full_o & out_of_reset_r.
- v_o = (rptr≠wptr) & (inflight_o<max_inflight_p) & out_of_reset_r.
- data_o = mem[rptr low bits], combinational from registered state.
- Enqueue on v_i&ready_o: mem[wptr]←data_i, wptr+1.
- Issue on yumi_i: rptr+1.
- Commit on commit_v_i with inflight_o>0: cptr+1. Commit with inflight_o==0 is ignored. A sim-only assertion fires.
- Next-state priority, evaluated on the same cycle:
  1. Compute cptr_n = cptr + commit.
  2. roll_v_i: rptr←cptr_n; a same-cycle yumi_i is discarded and that entry is reissued.
  3. clr_v_i without roll: wptr←rptr_n, where rptr_n includes a same-cycle yumi_i.
  4. clr_v_i with roll: wptr←cptr_n and rptr←cptr_n. All uncommitted entries are dropped.
  5. Enqueue in a clr_v_i cycle: the handshake completes, the payload is discarded, wptr is not incremented.
- yumi_i with v_o=0 is illegal; a sim-only assertion fires.

## Timing
- Reset (reset_n_i low, asynchronous):
  - all pointers 0; out_of_reset_r=0
  - ready_o=0, v_o=0, count_o=0, inflight_o=0, empty_o=1, full_o=0
- out_of_reset_r sets on the first posedge after reset_n_i rises. ready_o rises in that cycle.
- Enqueue→v_o latency: 1 cycle, no bypass. An entry written at edge N is visible on v_o/data_o after edge N.
- Issue throughput: one per cycle while v_o=1.
- Commit latency: freed slot is visible on ready_o one cycle after commit_v_i. Full→ready same cycle as commit is not provided.
- Rollback: data_o shows the oldest uncommitted entry the cycle after roll_v_i.
- Counters: plain subtraction of ptr_width_lp-bit pointers modulo 2^ptr_width_lp, truncated to cnt_width_lp.
- Reset mid-operation: contents are abandoned and pointers cleared immediately. No output glitches to 1.

## Test plan
- Fill/drain, els_p=8:
  - enqueue 8 entries 0x10..0x17 → full_o=1, ready_o=0
  - issue+commit all 8 → data_o order 0x10..0x17, empty_o=1
  - pointers wrap and MSB toggles on the next 8
- In-flight cap, max_inflight_p=2:
  - enqueue 4, hold commit_v_i=0 → exactly 2 issues, v_o=0, inflight_o=2
  - one commit → v_o=1 next cycle
- Rollback:
  - enqueue A,B,C; issue A,B; commit A; assert roll_v_i with yumi_i on C → next data_o=B
  - reissue order B,C; inflight_o=0 after roll
- Clear:
  - enqueue A..D; issue A; assert clr_v_i with v_i=1 (E) → count_o=1, E dropped
  - assert clr_v_i+roll_v_i → count_o=0, empty_o=1
- Async reset:
  - with 5 entries, 2 in flight, pull reset_n_i low mid-cycle → outputs reach reset values before the next edge
  - ready_o=1 exactly one edge after release
- Random: constrained random v_i/yumi_i/commit/roll/clr against a scoreboard queue model for 10k cycles → no mismatches, no assertion failures.
